// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: raster position, syncs and strobes produced by vga_timing_gen.
// The master modport drives the bundle and the slave modport consumes it.
interface vga_timing_gen_if;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       hsync;
  logic       vsync;
  logic       visible;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output hpos,
    output vpos,
    output hsync,
    output vsync,
    output visible,
    output line_start,
    output frame_start,
    output frame_count
  );

  modport slave (
    input hpos,
    input vpos,
    input hsync,
    input vsync,
    input visible,
    input line_start,
    input frame_start,
    input frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters with registered syncs, visible flag,
// line/frame strobes and a frame counter, all aligned to the position they describe.
module vga_timing_gen #(
  parameter int unsigned H_VIEW      = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VIEW      = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned HTotal = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VIEW + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast    = 10'(HTotal - 1);
  localparam logic [9:0] VLast    = 10'(VTotal - 1);
  localparam logic [9:0] HView    = 10'(H_VIEW);
  localparam logic [9:0] VView    = 10'(V_VIEW);
  localparam logic [9:0] HSyncBeg = 10'(H_VIEW + H_FRONT);
  localparam logic [9:0] HSyncEnd = 10'(H_VIEW + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VSyncBeg = 10'(V_VIEW + V_FRONT);
  localparam logic [9:0] VSyncEnd = 10'(V_VIEW + V_FRONT + V_SYNC - 1);

  logic [9:0] hpos_d, hpos_q;
  logic [9:0] vpos_d, vpos_q;
  logic [7:0] frame_count_d, frame_count_q;
  logic       hsync_d, hsync_q;
  logic       vsync_d, vsync_q;
  logic       visible_d, visible_q;
  logic       line_start_d, line_start_q;
  logic       frame_start_d, frame_start_q;

  logic [9:0] h_nxt, v_nxt;
  logic       line_wrap, frame_wrap;

  // Position the raster moves to on an enabled clock.
  always_comb begin
    line_wrap  = (hpos_q == HLast);
    frame_wrap = line_wrap && (vpos_q == VLast);
    h_nxt      = line_wrap ? 10'd0 : hpos_q + 10'd1;
    v_nxt      = vpos_q;
    if (line_wrap) begin
      v_nxt = (vpos_q == VLast) ? 10'd0 : vpos_q + 10'd1;
    end
  end

  // Decodes are taken from the next position so the registered outputs line up with it.
  always_comb begin
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_count_d = frame_count_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    visible_d     = visible_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (en) begin
      hpos_d        = h_nxt;
      vpos_d        = v_nxt;
      frame_count_d = frame_wrap ? frame_count_q + 8'd1 : frame_count_q;
      hsync_d       = ((h_nxt >= HSyncBeg) && (h_nxt <= HSyncEnd)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d       = ((v_nxt >= VSyncBeg) && (v_nxt <= VSyncEnd)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      visible_d     = (h_nxt < HView) && (v_nxt < VView);
      line_start_d  = (h_nxt == 10'd0);
      frame_start_d = (h_nxt == 10'd0) && (v_nxt == 10'd0);
    end
  end

  // Reset parks the raster on the last pixel so the first enabled clock lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q        <= HLast;
      vpos_q        <= VLast;
      frame_count_q <= 8'hFF;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      visible_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      visible_q     <= visible_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.hpos        = hpos_q;
  assign vga.vpos        = vpos_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.visible     = visible_q;
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;
  assign vga.frame_count = frame_count_q;

endmodule
